fetch_buffer: RTL and testbench

First-word-fall-through instruction buffer that sits between the fetch stage's PC/instruction-memory path and the decode stage. Fetch writes {PC, instruction} pairs into it; decode reads them out in order. It decouples a stalling decode from a free-running fetch and discards all buffered instructions on a branch redirect.

---
 rtl/fetch_buffer.sv | 69 ++++++
 tb/tb_fetch_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// First-word-fall-through {pc, instr} buffer between fetch and decode.
// Flush discards all entries; storage array is not reset, only pointers and count.
module fetch_buffer #(
  parameter int WORD  = 64,
  parameter int INSTR = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [WORD-1:0]            wr_pc,
  input  logic [INSTR-1:0]           wr_instr,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WORD-1:0]            rd_pc,
  output logic [INSTR-1:0]           rd_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high (and flush is low); ready/valid here depend on state only, never on inputs.
  logic [WORD-1:0]  pc_mem    [DEPTH];
  logic [INSTR-1:0] instr_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign wr_ready = (count != CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign push     = wr_valid && wr_ready && !flush;
  assign pop      = rd_valid && rd_ready && !flush;

  assign rd_pc    = rd_valid ? pc_mem[rd_ptr]    : '0;
  assign rd_instr = rd_valid ? instr_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= wr_pc;
      instr_mem[wr_ptr] <= wr_instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: driver pushes expected entries into a queue,
// a negedge monitor pops and compares every head entry that decode consumes.
module tb_fetch_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_pc;
  logic [31:0] wr_instr;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_pc;
  logic [31:0] rd_instr;
  logic [2:0]  count;

  logic [95:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  fetch_buffer #(.WORD(64), .INSTR(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pc(wr_pc), .wr_instr(wr_instr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [63:0] pc, input logic [31:0] instr);
    wr_valid = 1'b1;
    wr_pc    = pc;
    wr_instr = instr;
    exp_q.push_back({pc, instr});
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && rd_valid && rd_ready && !flush) begin
      logic [95:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected: actual pc=0x%0h required=no entry", rd_pc);
      end else begin
        e = exp_q.pop_front();
        check("mon_pc", rd_pc, e[95:32]);
        check("mon_instr", {32'h0, rd_instr}, {32'h0, e[31:0]});
      end
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    wr_pc = '0; wr_instr = '0;

    // reset / idle
    repeat (2) tick();
    check("rst_count", 64'(count), 0);
    check("rst_rd_valid", 64'(rd_valid), 0);
    reset = 1'b1;
    tick();
    check("idle_count", 64'(count), 0);
    check("idle_rd_valid", 64'(rd_valid), 0);
    check("idle_rd_pc", rd_pc, 0);
    check("idle_rd_instr", 64'(rd_instr), 0);
    check("idle_wr_ready", 64'(wr_ready), 1);

    // fill and drain order
    for (int i = 0; i < 4; i++) push_one(64'(4 * i), 32'h8B020020 + 32'(i));
    check("fill_count", 64'(count), 4);
    check("fill_wr_ready", 64'(wr_ready), 0);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", rd_pc, 64'(4 * i));
      tick();
    end
    rd_ready = 1'b0;
    check("drain_rd_valid", 64'(rd_valid), 0);
    check("drain_rd_pc_zero", rd_pc, 0);

    // full with simultaneous push/pop
    for (int i = 0; i < 4; i++) push_one(64'h20 + 64'(4 * i), 32'hA0 + 32'(i));
    check("full_count", 64'(count), 4);
    wr_valid = 1'b1; wr_pc = 64'h10; wr_instr = 32'h0000_0B10;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("fullpp_count", 64'(count), 3);
    check("fullpp_wr_ready", 64'(wr_ready), 1);
    exp_q.push_back({64'h10, 32'h0000_0B10});
    tick();
    wr_valid = 1'b0;
    check("full_retry_count", 64'(count), 4);
    drain(4);
    check("full_drained", 64'(count), 0);

    // steady streaming across pointer wrap
    rd_ready = 1'b1;
    push_one(64'h100, 32'h1000);
    wr_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      check("stream_count", 64'(count), 1);
      check("stream_lag_pc", rd_pc, 64'h100 + 64'(4 * (k - 1)));
      wr_pc    = 64'h100 + 64'(4 * k);
      wr_instr = 32'h1000 + 32'(k);
      exp_q.push_back({wr_pc, wr_instr});
      tick();
    end
    wr_valid = 1'b0;
    tick();
    rd_ready = 1'b0;
    check("stream_end_count", 64'(count), 0);

    // flush priority
    for (int i = 0; i < 3; i++) push_one(64'h300 + 64'(4 * i), 32'h3000 + 32'(i));
    check("preflush_count", 64'(count), 3);
    flush = 1'b1; wr_valid = 1'b1; wr_pc = 64'h200; wr_instr = 32'h2000; rd_ready = 1'b1;
    tick();
    flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    exp_q.delete();
    check("flush_count", 64'(count), 0);
    check("flush_rd_valid", 64'(rd_valid), 0);
    check("flush_wr_ready", 64'(wr_ready), 1);
    push_one(64'h204, 32'h2004);
    check("postflush_count", 64'(count), 1);
    check("postflush_pc", rd_pc, 64'h204);
    check("postflush_instr", 64'(rd_instr), 64'h2004);
    drain(1);

    // asynchronous reset mid-stream
    push_one(64'h400, 32'h4000);
    push_one(64'h404, 32'h4004);
    check("prereset_count", 64'(count), 2);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("areset_rd_valid", 64'(rd_valid), 0);
    check("areset_count", 64'(count), 0);
    check("areset_rd_pc", rd_pc, 0);
    check("areset_wr_ready", 64'(wr_ready), 1);
    exp_q.delete();
    tick();
    reset = 1'b1;
    push_one(64'h500, 32'h5000);
    check("postreset_count", 64'(count), 1);
    check("postreset_pc", rd_pc, 64'h500);
    drain(1);

    check("queue_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
